alu_exec_stage: RTL

//  Execute stage that sits directly downstream of the ALU controller.
//  - Takes a decoded 4-bit op3 plus two operands and a shift amount.
//  - Produces the result, a write-back enable and S/Z/C/V condition flags.
//  - ALU ops take one cycle; shift ops run iteratively, one bit per cycle.
//  - Holds the architectural condition-code register (flags_q) read by the branch unit.
//  - Valid/ready handshake on both sides.

---
 rtl/simple_isa_pkg.sv | 47 ++++
 rtl/alu_exec_stage_if.sv | 29 ++
 rtl/alu_shift_step.sv | 35 +++
 rtl/alu_exec_stage.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/simple_isa_pkg.sv
// Shared encodings for the simple ISA execute path: opcodes, condition-flag
// bit positions and execute-stage FSM states.
package simple_isa_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SLR = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_IN  = 4'b1100;
  localparam logic [3:0] OP_OUT = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int F_S = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Shift ops occupy 10xx; the low two bits select the shift flavour.
  function automatic logic is_shift(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  function automatic logic [3:0] pack_flags(input logic s, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f      = '0;
    f[F_S] = s;
    f[F_Z] = z;
    f[F_C] = c;
    f[F_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Handshake and data bundle between the ALU controller (master) and the
// execute stage (slave), including the result side and condition codes.
interface alu_exec_stage_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CNT_W-1:0] shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             rd_we;
  logic             flag_we;
  logic [3:0]       flags_q;

  modport master (
    output in_valid, op3, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, rd_we, flag_we, flags_q
  );

  modport slave (
    input  in_valid, op3, a, b, shamt, out_ready,
    output in_ready, out_valid, result, rd_we, flag_we, flags_q
  );
endinterface

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate step used by the iterative shifter; mode is the low
// two bits of the shift opcode (SLL, rotate-left, SRL, SRA).
module alu_shift_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] val_next,
  output logic             bit_out
);

  always_comb begin
    val_next = val;
    bit_out  = 1'b0;
    case (mode)
      2'b00: begin
        val_next = {val[WIDTH-2:0], 1'b0};
        bit_out  = val[WIDTH-1];
      end
      2'b01: begin
        val_next = {val[WIDTH-2:0], val[WIDTH-1]};
        bit_out  = val[WIDTH-1];
      end
      2'b10: begin
        val_next = {1'b0, val[WIDTH-1:1]};
        bit_out  = val[0];
      end
      default: begin
        val_next = {val[WIDTH-1], val[WIDTH-1:1]};
        bit_out  = val[0];
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops, iterative one-bit-per-cycle shifts,
// and the architectural S/Z/C/V condition-code register.
module alu_exec_stage
  import simple_isa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_exec_stage_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic             in_ready_c, out_valid_c, accept, start_shift;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       pend_flags_q, cc_q;
  logic             rd_we_q, flag_we_q;

  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, alu_rd_we, alu_flag_we;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .val      (result_q),
    .mode     (mode_q),
    .val_next (step_val),
    .bit_out  (step_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready_c = 1'b1;
      ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE: begin
        out_valid_c = 1'b1;
        in_ready_c  = bus.out_ready;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    accept      = bus.in_valid & in_ready_c;
    start_shift = accept & is_shift(bus.op3) & (bus.shamt != '0);
    if (accept) state_d = start_shift ? ST_SHIFT : ST_DONE;
  end

  // Shifts with a zero amount fall through here and complete in one cycle.
  always_comb begin
    alu_r       = '0;
    alu_c       = 1'b0;
    alu_v       = 1'b0;
    alu_rd_we   = 1'b0;
    alu_flag_we = 1'b0;
    case (bus.op3)
      OP_ADD: begin
        {alu_c, alu_r} = {1'b0, bus.a} + {1'b0, bus.b};
        alu_v       = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (alu_r[WIDTH-1] != bus.a[WIDTH-1]);
        alu_rd_we   = 1'b1;
        alu_flag_we = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_r       = bus.a - bus.b;
        alu_c       = bus.a < bus.b;
        alu_v       = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (alu_r[WIDTH-1] != bus.a[WIDTH-1]);
        alu_rd_we   = (bus.op3 == OP_SUB);
        alu_flag_we = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_MOV: begin
        case (bus.op3)
          OP_AND:  alu_r = bus.a & bus.b;
          OP_OR:   alu_r = bus.a | bus.b;
          OP_XOR:  alu_r = bus.a ^ bus.b;
          default: alu_r = bus.b;
        endcase
        alu_rd_we   = 1'b1;
        alu_flag_we = 1'b1;
      end
      OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
        alu_r       = bus.a;
        alu_rd_we   = 1'b1;
        alu_flag_we = 1'b1;
      end
      OP_IN: begin
        alu_r     = bus.b;
        alu_rd_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      pend_flags_q <= '0;
      rd_we_q      <= 1'b0;
      flag_we_q    <= 1'b0;
      cc_q         <= '0;
    end else begin
      if (accept) begin
        mode_q <= bus.op3[1:0];
        cnt_q  <= bus.shamt;
        if (start_shift) begin
          result_q  <= bus.a;
          rd_we_q   <= 1'b1;
          flag_we_q <= 1'b1;
        end else begin
          result_q     <= alu_r;
          pend_flags_q <= pack_flags(alu_r[WIDTH-1], alu_r == '0, alu_c, alu_v);
          rd_we_q      <= alu_rd_we;
          flag_we_q    <= alu_flag_we;
        end
      end else if (state_q == ST_SHIFT) begin
        result_q     <= step_val;
        pend_flags_q <= pack_flags(step_val[WIDTH-1], step_val == '0, step_bit, 1'b0);
        cnt_q        <= cnt_q - CNT_W'(1);
      end
      if ((state_q == ST_DONE) && bus.out_ready && flag_we_q) cc_q <= pend_flags_q;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.rd_we     = rd_we_q & out_valid_c;
  assign bus.flag_we   = flag_we_q & out_valid_c;
  assign bus.flags_q   = cc_q;

endmodule
